// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a_in - b_in), LSB first, one full-subtractor step per clock.
// Optional macro SERIAL_SUB_SAT_EN saturates d_out to zero when the final borrow is set.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] d_out,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              borrow_q, borrow_d;

  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  // Single full-subtractor cell working on the current LSBs.
  assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign r_next   = {diff_bit, r_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    borrow_d = borrow_q;

    case (state_q)
      StIdle: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          r_d     = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = r_next;
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          dout_d   = r_next;
          borrow_d = br_next;
`ifdef SERIAL_SUB_SAT_EN
          if (br_next) begin
            dout_d = '0;
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy_out   = (state_q != StIdle);
  assign done_out   = (state_q == StDone);
  assign d_out      = dout_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and model-checked bench for serial_sub at WIDTH 8, 16 and 2.
// Honours SERIAL_SUB_SAT_EN in its expected values.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st8, busy8, done8, br8;
  logic [7:0]  a8, b8, d8;
  logic        st16, busy16, done16, br16;
  logic [15:0] a16, b16, d16;
  logic        st2, busy2, done2, br2;
  logic [1:0]  a2, b2, d2;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_in(st8), .a_in(a8), .b_in(b8),
    .busy_out(busy8), .done_out(done8), .d_out(d8), .borrow_out(br8)
  );
  serial_sub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start_in(st16), .a_in(a16), .b_in(b16),
    .busy_out(busy16), .done_out(done16), .d_out(d16), .borrow_out(br16)
  );
  serial_sub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_in(st2), .a_in(a2), .b_in(b2),
    .busy_out(busy2), .done_out(done2), .d_out(d2), .borrow_out(br2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_d(input int w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    logic [63:0] r;
    m = (64'd1 << w) - 64'd1;
    r = (a - b) & m;
`ifdef SERIAL_SUB_SAT_EN
    if (a < b) r = '0;
`endif
    return r;
  endfunction

  function automatic logic done_w(input int w);
    case (w)
      2:       return done2;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_w(input int w);
    case (w)
      2:       return busy2;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  // One start pulse; lat counts sampled cycles from the accept edge up to done (bounded).
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] d, output logic br, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    case (w)
      2:       begin a2 = a[1:0];  b2 = b[1:0];  st2 = 1'b1;  end
      16:      begin a16 = a[15:0]; b16 = b[15:0]; st16 = 1'b1; end
      default: begin a8 = a[7:0];  b8 = b[7:0];  st8 = 1'b1;  end
    endcase
    @(negedge clk);
    st2 = 1'b0; st16 = 1'b0; st8 = 1'b0;
    lat = 1;
    busy_cnt = busy_w(w) ? 1 : 0;
    while (!done_w(w) && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy_w(w)) busy_cnt++;
    end
    case (w)
      2:       begin d = 64'(d2);  br = br2;  end
      16:      begin d = 64'(d16); br = br16; end
      default: begin d = 64'(d8);  br = br8;  end
    endcase
  endtask

  initial begin
    logic [63:0] d, a, b;
    logic        br;
    int          lat, bc, ndone, t1, t2;
    logic [7:0]  dcap;
    logic        brcap;

    rst = 1'b1; st8 = 0; st16 = 0; st2 = 0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy8), 0);
    check_eq("rst_done", 64'(done8), 0);
    check_eq("rst_d", 64'(d8), 0);
    check_eq("rst_borrow", 64'(br8), 0);
    rst = 1'b0;

    // Basic operation with latency and busy duration.
    run_op(8, 64'h5A, 64'h3C, d, br, lat, bc);
    check_eq("t1_latency", 64'(lat), 9);
    check_eq("t1_d", d, 64'h1E);
    check_eq("t1_borrow", 64'(br), 0);
    @(negedge clk);
    check_eq("t1_done_pulse", 64'(done8), 0);
    check_eq("t1_busy_after", 64'(busy8), 0);
    check_eq("t1_busy_cycles", 64'(bc), 9);
    check_eq("t1_d_hold", 64'(d8), 64'h1E);

    run_op(8, 64'h10, 64'h20, d, br, lat, bc);
    check_eq("t2_d", d, exp_d(8, 64'h10, 64'h20));
    check_eq("t2_borrow", 64'(br), 1);

    // Back-to-back with start held high.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; st8 = 1'b1;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01;
    ndone = 0; t1 = 0; t2 = 0;
    for (int i = 1; i < 40 && ndone < 2; i++) begin
      if (done8) begin
        if (ndone == 0) begin
          t1 = i;
          check_eq("t3_first_d", 64'(d8), 64'h00);
          check_eq("t3_first_borrow", 64'(br8), 0);
        end else begin
          t2 = i;
          check_eq("t3_second_d", 64'(d8), exp_d(8, 64'h00, 64'h01));
          check_eq("t3_second_borrow", 64'(br8), 1);
          st8 = 1'b0;
        end
        ndone++;
      end
      @(negedge clk);
    end
    st8 = 1'b0;
    check_eq("t3_done_count", 64'(ndone), 2);
    check_eq("t3_gap", 64'(t2 - t1), 10);
    repeat (12) @(negedge clk);

    // Start pulsed mid-run must be ignored.
    a8 = 8'h80; b8 = 8'h01; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    ndone = 0; dcap = '0; brcap = 1'b1;
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin a8 = 8'h01; b8 = 8'h02; st8 = 1'b1; end
      else st8 = 1'b0;
      if (done8) begin ndone++; dcap = d8; brcap = br8; end
      @(negedge clk);
    end
    st8 = 1'b0;
    check_eq("t4_done_count", 64'(ndone), 1);
    check_eq("t4_d", 64'(dcap), 64'h7F);
    check_eq("t4_borrow", 64'(brcap), 0);

    // Reset aborts a run in flight.
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h11; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_busy", 64'(busy8), 0);
    check_eq("t5_done", 64'(done8), 0);
    check_eq("t5_d", 64'(d8), 0);
    check_eq("t5_borrow", 64'(br8), 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check_eq("t5_no_done", 64'(ndone), 0);
    run_op(8, 64'h03, 64'h01, d, br, lat, bc);
    check_eq("t5_after_d", d, 64'h02);
    check_eq("t5_after_borrow", 64'(br), 0);

    // WIDTH=2 exhaustive.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 64'(i); b = 64'(j);
        run_op(2, a, b, d, br, lat, bc);
        check_eq("w2_d", d, exp_d(2, a, b));
        check_eq("w2_borrow", 64'(br), 64'(a < b));
      end
    end

    // WIDTH=16 random sweep.
    for (int n = 0; n < 1000; n++) begin
      a = 64'($urandom & 32'hFFFF);
      b = (n % 10 == 0) ? a : 64'($urandom & 32'hFFFF);
      run_op(16, a, b, d, br, lat, bc);
      check_eq("w16_d", d, exp_d(16, a, b));
      check_eq("w16_borrow", 64'(br), 64'(a < b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Parametrised, bit-serial WIDTH-bit subtractor computing a_in - b_in, LSB first, one bit per clock.
- Reuses the half/full-subtractor borrow equations inside a registered datapath with a start/busy/done handshake.
- Arithmetic building block for area-constrained datapaths: one full-subtractor cell plus shift registers instead of a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  request an operation; sampled only in IDLE.
- a_in  input  WIDTH  minuend; captured on an accepted start.
- b_in  input  WIDTH  subtrahend; captured on an accepted start.
- busy_out  output  1  high while an operation is in progress (RUN or DONE).
- done_out  output  1  one-cycle pulse when d_out/borrow_out carry a new result.
- d_out  output  WIDTH  difference (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow: 1 when a < b (unsigned).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy_out=0, done_out=0, d_out=0, borrow_out=0, internal shift registers, borrow flop and bit counter cleared. rst has priority over every other input and aborts an operation in flight with no done_out.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_in=1 at edge k: capture a_in and b_in into shift regs A and B, borrow flop br=0, counter=0, go to RUN; busy_out=1 from this edge.
  - start_in=0: stay in IDLE.
- RUN, once per edge:
  - diff bit = A[0]^B[0]^br.
  - br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&br).
  - diff bit shifts into the MSB of result reg R; A and B shift right; counter increments.
  - At the edge where counter reaches WIDTH-1 (WIDTH RUN edges total, k+1..k+WIDTH), go to DONE and register d_out = final R and borrow_out = br_next.
- DONE (one cycle): done_out=1, busy_out=1. Next edge: go to IDLE, done_out=0, busy_out=0.
- Latency: start accepted at edge k, done_out high after edge k+WIDTH, busy_out low after edge k+WIDTH+1. Throughput: one operation per WIDTH+2 cycles.
- start_in in RUN or DONE is ignored, with no queuing.
- Back-to-back: start_in held high re-launches at the first IDLE edge.
- a_in and b_in may change freely after capture; the result depends only on captured values.
- d_out and borrow_out hold their last result until the next DONE or reset; they never show partial results.
- Equal operands give d_out=0, borrow_out=0. Wrap-around is modulo 2^WIDTH.
- Counter width is $clog2(WIDTH)+1; there must be no overflow at WIDTH=64.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: when the final borrow is 1, d_out is forced to 0 (unsigned saturation at zero) at the DONE edge. borrow_out is still 1, flagging that saturation occurred.
- Undefined: d_out is the modulo-2^WIDTH difference; no saturation logic is synthesised.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start 1 cycle -> done_out after 8 edges, d_out=0x1E, borrow_out=0, done_out exactly 1 cycle, busy_out high 9 cycles.
- WIDTH=8, a=0x10, b=0x20 -> d_out=0xF0, borrow_out=1. With SERIAL_SUB_SAT_EN: d_out=0x00, borrow_out=1.
- WIDTH=8, a=0xFF, b=0xFF, then a=0x00, b=0x01 back-to-back with start_in held high -> 0x00/0, then 0xFF/1. Second done_out exactly WIDTH+2 cycles after the first.
- start_in pulsed in mid-RUN with different operands -> ignored; result matches the first operands; only one done_out.
- rst asserted at RUN cycle 4 -> next edge all outputs 0, state IDLE, no done_out. A new start then completes normally (a=0x03, b=0x01 -> 0x02/0).
- WIDTH=16 sweep: random 1000 operand pairs vs a reference model (a-b) mod 2^16 and borrow a<b; also WIDTH=2 exhaustive (16 pairs).
